// File: rtl/h2f_vram_line_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : h2f_vram_line_assembler
//  Brief    : Avalon-MM write slave that gathers 32-bit HPS writes into
//             128-bit VRAM lines and emits single-cycle line commits.
//             Lines beyond the mapped VRAM space are dropped; a status
//             register at the top word address exposes commit/drop counters.
//  Revision : 1.0 - initial release
// ============================================================================
module h2f_vram_line_assembler (
    input  logic         clk,
    input  logic         reset,
    input  logic [13:0]  avs_address,
    input  logic         avs_write,
    input  logic [31:0]  avs_writedata,
    input  logic [3:0]   avs_byteenable,
    input  logic         avs_read,
    output logic [31:0]  avs_readdata,
    output logic [11:0]  h2f_vram_wraddr,
    output logic         h2f_vram_wren,
    output logic [127:0] h2f_vram_wrdata
);

    localparam logic [11:0] c_LAST_LINE = 12'hD13;
    localparam logic [13:0] c_CSR_ADDR  = 14'h3FFF;
    localparam logic [1:0]  c_COMMIT_LANE = 2'd3;

    // Line assembly state
    logic [127:0] r_line_buf;
    logic         r_pend_valid;
    logic [11:0]  r_pend_line;

    // Status counters
    logic [15:0]  r_commit_cnt;
    logic [15:0]  r_drop_cnt;

    // Registered outputs
    logic [31:0]  r_readdata;
    logic         r_wren;
    logic [11:0]  r_wraddr;
    logic [127:0] r_wrdata;

    // Decoded request
    logic [11:0]  w_line;
    logic [1:0]   w_lane;
    logic         w_is_csr;
    logic         w_in_range;
    logic         w_line_write;
    logic         w_new_line;
    logic         w_abandon;
    logic         w_commit;
    logic         w_drop_inc;
    logic [15:0]  w_drop_next;
    logic [15:0]  w_byte_we;
    logic [127:0] w_byte_mask;
    logic [127:0] w_base;
    logic [127:0] w_merged;

    assign w_line       = avs_address[13:2];
    assign w_lane       = avs_address[1:0];
    assign w_is_csr     = (avs_address == c_CSR_ADDR);
    // The CSR word lives in line 12'hFFF, so it can never look in-range.
    assign w_in_range   = !w_is_csr && (w_line <= c_LAST_LINE);
    assign w_line_write = avs_write && w_in_range;
    assign w_new_line   = !r_pend_valid || (w_line != r_pend_line);
    assign w_abandon    = r_pend_valid && (w_line != r_pend_line);
    assign w_commit     = w_line_write && (w_lane == c_COMMIT_LANE);
    // Only one drop source can fire per write: out-of-range or abandoned line.
    assign w_drop_inc   = avs_write && !w_is_csr && (!w_in_range || w_abandon);
    assign w_drop_next  = (r_drop_cnt == 16'hFFFF) ? r_drop_cnt : (r_drop_cnt + 16'd1);

    // Byte-granular merge of the incoming word into the (possibly cleared) line
    always_comb begin
        w_byte_we   = '0;
        w_byte_mask = '0;
        for (int l = 0; l < 4; l++) begin
            for (int b = 0; b < 4; b++) begin
                w_byte_we[l*4+b] = (w_lane == l[1:0]) && avs_byteenable[b];
            end
        end
        for (int i = 0; i < 16; i++) begin
            w_byte_mask[i*8 +: 8] = {8{w_byte_we[i]}};
        end
        w_base   = w_new_line ? 128'h0 : r_line_buf;
        w_merged = (w_base & ~w_byte_mask) | ({4{avs_writedata}} & w_byte_mask);
    end

    // Pending line tracking; lane 3 closes the line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_line_buf   <= '0;
            r_pend_valid <= 1'b0;
            r_pend_line  <= '0;
        end else if (w_line_write) begin
            r_line_buf <= w_merged;
            if (w_lane == c_COMMIT_LANE) begin
                r_pend_valid <= 1'b0;
            end else begin
                r_pend_valid <= 1'b1;
                r_pend_line  <= w_line;
            end
        end
    end

    // Commit and drop counters; a CSR write clears both
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_commit_cnt <= '0;
            r_drop_cnt   <= '0;
        end else if (avs_write && w_is_csr) begin
            r_commit_cnt <= '0;
            r_drop_cnt   <= '0;
        end else begin
            if (w_commit) begin
                r_commit_cnt <= r_commit_cnt + 16'd1;
            end
            if (w_drop_inc) begin
                r_drop_cnt <= w_drop_next;
            end
        end
    end

    // One-cycle commit strobe; address/data hold between commits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wren   <= 1'b0;
            r_wraddr <= '0;
            r_wrdata <= '0;
        end else begin
            r_wren <= w_commit;
            if (w_commit) begin
                r_wraddr <= w_line;
                r_wrdata <= w_merged;
            end
        end
    end

    // Read port: counters sampled before any same-cycle write takes effect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (avs_read) begin
            r_readdata <= w_is_csr ? {r_commit_cnt, r_drop_cnt} : 32'h0;
        end
    end

    assign avs_readdata    = r_readdata;
    assign h2f_vram_wren   = r_wren;
    assign h2f_vram_wraddr = r_wraddr;
    assign h2f_vram_wrdata = r_wrdata;

endmodule
`default_nettype wire

// File: tb/tb_h2f_vram_line_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_h2f_vram_line_assembler
//  Brief    : Self-checking bench for h2f_vram_line_assembler: directed
//             scenarios plus randomized traffic against a byte-array model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_h2f_vram_line_assembler;

    localparam logic [13:0] c_CSR = 14'h3FFF;

    logic         clk;
    logic         reset;
    logic [13:0]  avs_address;
    logic         avs_write;
    logic [31:0]  avs_writedata;
    logic [3:0]   avs_byteenable;
    logic         avs_read;
    logic [31:0]  avs_readdata;
    logic [11:0]  h2f_vram_wraddr;
    logic         h2f_vram_wren;
    logic [127:0] h2f_vram_wrdata;

    h2f_vram_line_assembler u_dut (
        .clk             (clk),
        .reset           (reset),
        .avs_address     (avs_address),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_byteenable  (avs_byteenable),
        .avs_read        (avs_read),
        .avs_readdata    (avs_readdata),
        .h2f_vram_wraddr (h2f_vram_wraddr),
        .h2f_vram_wren   (h2f_vram_wren),
        .h2f_vram_wrdata (h2f_vram_wrdata)
    );

    initial clk = 1'b0;
    // 100 MHz free-running clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the open line as 16 bytes, counters as plain integers
    logic [7:0]   m_bytes [16];
    bit           m_pend;
    logic [11:0]  m_pend_line;
    int           m_commit;
    int           m_drop;
    logic [31:0]  m_rd;
    logic         m_wren;
    logic [11:0]  m_wraddr;
    logic [127:0] m_wrdata;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bytes[i] = 8'h00;
        m_pend      = 1'b0;
        m_pend_line = '0;
        m_commit    = 0;
        m_drop      = 0;
        m_rd        = '0;
        m_wren      = 1'b0;
        m_wraddr    = '0;
        m_wrdata    = '0;
    endtask

    task automatic model_drop();
        if (m_drop < 65535) m_drop = m_drop + 1;
    endtask

    task automatic model_apply(input bit we, input logic [13:0] addr,
                               input logic [31:0] wd, input logic [3:0] be, input bit rd);
        logic [11:0] line;
        int          lane;
        line = addr[13:2];
        lane = int'(addr[1:0]);
        if (rd) m_rd = (addr == c_CSR) ? ((m_commit << 16) | m_drop) : 32'h0;
        m_wren = 1'b0;
        if (we) begin
            if (addr == c_CSR) begin
                m_commit = 0;
                m_drop   = 0;
            end else if (line > 12'hD13) begin
                model_drop();
            end else begin
                if (!m_pend || line != m_pend_line) begin
                    if (m_pend) model_drop();
                    for (int i = 0; i < 16; i++) m_bytes[i] = 8'h00;
                end
                for (int b = 0; b < 4; b++)
                    if (be[b]) m_bytes[lane*4+b] = wd[b*8 +: 8];
                if (lane == 3) begin
                    m_wren   = 1'b1;
                    m_wraddr = line;
                    for (int i = 0; i < 16; i++) m_wrdata[i*8 +: 8] = m_bytes[i];
                    m_pend   = 1'b0;
                    m_commit = (m_commit + 1) % 65536;
                end else begin
                    m_pend      = 1'b1;
                    m_pend_line = line;
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("wren",     {127'h0, h2f_vram_wren}, {127'h0, m_wren});
        chk("wraddr",   {116'h0, h2f_vram_wraddr}, {116'h0, m_wraddr});
        chk("wrdata",   h2f_vram_wrdata, m_wrdata);
        chk("readdata", {96'h0, avs_readdata}, {96'h0, m_rd});
    endtask

    // One bus cycle: drive, advance model, clock, then check just after the edge
    task automatic step(input bit we, input logic [13:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input bit rd);
        avs_write      = we;
        avs_address    = addr;
        avs_writedata  = wd;
        avs_byteenable = be;
        avs_read       = rd;
        model_apply(we, addr, wd, be, rd);
        @(posedge clk);
        #1;
        avs_write = 1'b0;
        avs_read  = 1'b0;
        check_outputs();
    endtask

    task automatic wr(input logic [11:0] line, input logic [1:0] lane,
                      input logic [31:0] wd, input logic [3:0] be);
        step(1'b1, {line, lane}, wd, be, 1'b0);
    endtask

    task automatic csr_read();
        step(1'b0, c_CSR, 32'h0, 4'h0, 1'b1);
    endtask

    task automatic csr_clear();
        step(1'b1, c_CSR, 32'h0, 4'hF, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge
    task automatic async_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        chk({tag, "_wren"}, {127'h0, h2f_vram_wren}, 128'h0);
        chk({tag, "_wrdata"}, h2f_vram_wrdata, 128'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [11:0] line;
        reset          = 1'b1;
        avs_address    = '0;
        avs_write      = 1'b0;
        avs_writedata  = '0;
        avs_byteenable = '0;
        avs_read       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wren",   {127'h0, h2f_vram_wren}, 128'h0);
        chk("rst_wraddr", {116'h0, h2f_vram_wraddr}, 128'h0);
        chk("rst_wrdata", h2f_vram_wrdata, 128'h0);
        chk("rst_rdata",  {96'h0, avs_readdata}, 128'h0);
        @(negedge clk);
        reset = 1'b0;

        // Full line written in lane order
        wr(12'h400, 2'd0, 32'h11111111, 4'hF);
        wr(12'h400, 2'd1, 32'h22222222, 4'hF);
        wr(12'h400, 2'd2, 32'h33333333, 4'hF);
        chk("full_wren_early", {127'h0, h2f_vram_wren}, 128'h0);
        wr(12'h400, 2'd3, 32'h44444444, 4'hF);
        chk("full_wren", {127'h0, h2f_vram_wren}, 128'h1);
        chk("full_addr", {116'h0, h2f_vram_wraddr}, {116'h0, 12'h400});
        chk("full_data", h2f_vram_wrdata, 128'h44444444_33333333_22222222_11111111);
        csr_read();
        chk("full_commit_cnt", {112'h0, avs_readdata[31:16]}, 128'h1);
        chk("full_wren_single", {127'h0, h2f_vram_wren}, 128'h0);

        // Lone lane-3 write with sparse byteenable
        wr(12'hC05, 2'd3, 32'hAABBCCDD, 4'b0101);
        chk("partial_data", h2f_vram_wrdata, 128'h00BB00DD_00000000_00000000_00000000);

        // Abandoned line
        csr_clear();
        wr(12'h010, 2'd1, 32'hDEADBEEF, 4'hF);
        wr(12'h011, 2'd0, 32'h01020304, 4'hF);
        wr(12'h011, 2'd3, 32'h0A0B0C0D, 4'hF);
        chk("abandon_addr", {116'h0, h2f_vram_wraddr}, {116'h0, 12'h011});
        chk("abandon_data", h2f_vram_wrdata, 128'h0A0B0C0D_00000000_00000000_01020304);
        csr_read();
        chk("abandon_drop", {96'h0, avs_readdata}, {96'h0, 32'h0001_0001});

        // Map boundary
        csr_clear();
        wr(12'hD13, 2'd3, 32'h5A5A5A5A, 4'hF);
        chk("last_line_wren", {127'h0, h2f_vram_wren}, 128'h1);
        wr(12'hD14, 2'd3, 32'hA5A5A5A5, 4'hF);
        chk("oor_wren", {127'h0, h2f_vram_wren}, 128'h0);
        chk("oor_addr_hold", {116'h0, h2f_vram_wraddr}, {116'h0, 12'hD13});
        csr_read();
        chk("oor_counts", {96'h0, avs_readdata}, {96'h0, 32'h0001_0001});

        // Drop counter saturation, then CSR clear
        for (int i = 0; i < 70000; i++) wr(12'hE00, 2'(i), 32'h0, 4'hF);
        csr_read();
        chk("drop_sat", {112'h0, avs_readdata[15:0]}, {112'h0, 16'hFFFF});
        csr_clear();
        csr_read();
        chk("csr_cleared", {96'h0, avs_readdata}, 128'h0);

        // Back-to-back commits
        wr(12'h020, 2'd3, 32'h12345678, 4'hF);
        wr(12'h021, 2'd3, 32'h9ABCDEF0, 4'hF);
        chk("b2b_wren", {127'h0, h2f_vram_wren}, 128'h1);
        chk("b2b_addr", {116'h0, h2f_vram_wraddr}, {116'h0, 12'h021});

        // Asynchronous reset during a commit cycle and mid-line
        wr(12'h123, 2'd3, 32'hCAFEF00D, 4'hF);
        chk("pre_rst_wren", {127'h0, h2f_vram_wren}, 128'h1);
        async_reset("rst_commit");
        wr(12'h050, 2'd1, 32'hFFFFFFFF, 4'hF);
        async_reset("rst_midline");
        wr(12'h050, 2'd3, 32'h87654321, 4'hF);
        chk("rst_line_wren", {127'h0, h2f_vram_wren}, 128'h1);
        chk("rst_line_data", h2f_vram_wrdata, 128'h87654321_00000000_00000000_00000000);
        csr_read();
        chk("rst_line_cnt", {96'h0, avs_readdata}, {96'h0, 32'h0001_0000});

        // Randomized traffic concentrated on a few lines to exercise merging
        for (int n = 0; n < 4000; n++) begin
            logic [13:0] addr;
            bit          we;
            bit          rd;
            case ($urandom_range(0, 9))
                0, 1, 2: line = 12'h100;
                3, 4:    line = 12'h101;
                5:       line = 12'hD13;
                6:       line = 12'hD14;
                default: line = 12'($urandom_range(0, 4095));
            endcase
            addr = {line, 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 49) == 0) addr = c_CSR;
            we = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 3) == 0);
            if (rd && !we && $urandom_range(0, 1) == 0) addr = c_CSR;
            step(we, addr, $urandom, 4'($urandom_range(0, 15)), rd);
            if ($urandom_range(0, 499) == 0) async_reset("rand_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
